// File: rtl/rvh_noc_pkg.sv
// Shared NoC constants: flit head geometry and router port count.
package rvh_noc_pkg;
  localparam int FLIT_HEAD_W        = 33;
  localparam int QoS_Value_Width    = 4;
  localparam int LA_OUTPORT_OFFSET  = 4;
  localparam int LA_OUTPORT_W       = 3;
  localparam int OUTPUT_PORT_NUMBER = 6;
endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO with wrap-bit pointers and a combinational head.
module vc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  assign head_o  = mem[rd_ptr[AW-1:0]];
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/input_port_vc_buffer.sv
// Input-port VC buffer: per-VC FIFOs feeding switch allocation, with credit return
// and sticky overflow/underflow flags.
module input_port_vc_buffer
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM       = 4,
  parameter int VC_NUM_IDX_W = (VC_NUM > 1 ? $clog2(VC_NUM) : 1),
  parameter int VC_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flit_vld_i,
  input  logic [VC_NUM_IDX_W-1:0]       flit_vc_id_i,
  input  logic [FLIT_HEAD_W-1:0]        flit_i,
  output logic [VC_NUM-1:0]             vc_ctrl_head_vld_o,
  output logic [VC_NUM*FLIT_HEAD_W-1:0] vc_ctrl_head_o,
  input  logic                          inport_read_enable_sa_stage_i,
  input  logic [VC_NUM-1:0]             inport_read_vc_id_oh_i,
  output logic                          credit_vld_o,
  output logic [VC_NUM_IDX_W-1:0]       credit_vc_id_o,
  output logic                          overflow_err_o,
  output logic                          underflow_err_o
);
  logic [VC_NUM-1:0]       push;
  logic [VC_NUM-1:0]       pop;
  logic [VC_NUM-1:0]       empty;
  logic [VC_NUM-1:0]       full;
  logic [VC_NUM-1:0]       ovf_vec;
  logic                    rd_onehot;
  logic                    rd_ok;
  logic                    underflow_evt;
  logic [VC_NUM_IDX_W-1:0] rd_idx;

  assign rd_onehot = (inport_read_vc_id_oh_i != '0) &&
                     ((inport_read_vc_id_oh_i & (inport_read_vc_id_oh_i - VC_NUM'(1))) == '0);

  genvar v;
  generate
    for (v = 0; v < VC_NUM; v++) begin : g_vc
      logic wr_sel;
      assign wr_sel = flit_vld_i && (flit_vc_id_i == VC_NUM_IDX_W'(v));
      assign pop[v] = inport_read_enable_sa_stage_i && rd_onehot &&
                      inport_read_vc_id_oh_i[v] && !empty[v];
      // A same-cycle pop on a full VC frees the slot the write will land in.
      assign push[v]    = wr_sel && (!full[v] || pop[v]);
      assign ovf_vec[v] = wr_sel && full[v] && !pop[v];

      vc_fifo #(
        .WIDTH (FLIT_HEAD_W),
        .DEPTH (VC_DEPTH)
      ) u_vc_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push[v]),
        .pop     (pop[v]),
        .data_i  (flit_i),
        .head_o  (vc_ctrl_head_o[v*FLIT_HEAD_W +: FLIT_HEAD_W]),
        .empty_o (empty[v]),
        .full_o  (full[v])
      );
    end
  endgenerate

  assign vc_ctrl_head_vld_o = ~empty;
  assign rd_ok              = |pop;
  assign underflow_evt      = inport_read_enable_sa_stage_i &&
                              !(rd_onehot && |(inport_read_vc_id_oh_i & ~empty));

  always_comb begin
    rd_idx = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (inport_read_vc_id_oh_i[i]) rd_idx = VC_NUM_IDX_W'(i);
    end
  end

  // Credit id keeps its last value between credits; only the valid pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_vld_o    <= 1'b0;
      credit_vc_id_o  <= '0;
      overflow_err_o  <= 1'b0;
      underflow_err_o <= 1'b0;
    end else begin
      credit_vld_o <= rd_ok;
      if (rd_ok) credit_vc_id_o <= rd_idx;
      overflow_err_o  <= overflow_err_o | (|ovf_vec);
      underflow_err_o <= underflow_err_o | underflow_evt;
    end
  end
endmodule
